ct_f_spsram_arb_ctrl: RTL and testbench
=======================================

// Module: ct_f_spsram_arb_ctrl
// PURPOSE
//  Arbiter/sequencer in front of one single-port SRAM macro (ct_f_spsram_* family, 1 access/cycle).
//  Shares the macro between a read requester and a masked-write requester with valid/ready handshakes.
//  After reset it zero-fills the array, then grants one access per cycle.
//  Read priority by default; a starvation counter forces a write grant. Returns read data 1 cycle after grant.
// PARAMETERS
//  ADDR_WIDTH  11   SRAM address width; depth = 2**ADDR_WIDTH
//  DATA_WIDTH  144  SRAM word width
//  STARVE_MAX  4    consecutive stalled write cycles before write is forced to win (1..15)
//  INIT_EN     1    1: zero-fill sweep after reset; 0: go directly to RUN
// PORTS
//  CLK          in   1           clock; all state on posedge
//  RST          in   1           synchronous reset, active-high
//  init_done    out  1           1 = RUN state, requests accepted
//  rd_req_vld   in   1           read request valid
//  rd_req_addr  in   ADDR_WIDTH  read address
//  rd_req_rdy   out  1           read granted this cycle (accept = vld & rdy)
//  rd_rsp_vld   out  1           read data valid (no backpressure)
//  rd_rsp_data  out  DATA_WIDTH  read data (= sram_Q while rd_rsp_vld)
//  wr_req_vld   in   1           write request valid
//  wr_req_addr  in   ADDR_WIDTH  write address
//  wr_req_data  in   DATA_WIDTH  write data
//  wr_req_mask  in   DATA_WIDTH  per-bit write enable, 1 = write the bit
//  wr_req_rdy   out  1           write granted this cycle
//  sram_A       out  ADDR_WIDTH  macro address
//  sram_CEN     out  1           macro chip enable, active-low
//  sram_GWEN    out  1           macro global write enable, active-low
//  sram_WEN     out  DATA_WIDTH  macro bit write enable, active-low (= ~mask)
//  sram_D       out  DATA_WIDTH  macro write data
//  sram_Q       in   DATA_WIDTH  macro read data, valid the cycle after a read access
// BEHAVIOUR
//  Reset (RST=1 at posedge): state=INIT (RUN if INIT_EN=0), init ptr=0, starve cnt=0, rd_rsp_vld=0.
//   While RST=1 and during INIT: rd_req_rdy=0, wr_req_rdy=0.
//   Idle outputs: sram_CEN=1, sram_GWEN=1, sram_WEN='1, sram_A=0, sram_D=0, rd_rsp_data=0.
//  FSM INIT: each cycle write 0 to addr=ptr (CEN=0, GWEN=0, WEN='0, D=0); ptr++.
//   Transition at ptr==2**ADDR_WIDTH-1 write; init_done=1 from the next cycle. Sweep takes 2**ADDR_WIDTH cycles.
//  FSM RUN: terminal state until RST. init_done=1.
//  Grant (RUN, combinational in-cycle): wr_win = wr_req_vld & (!rd_req_vld | cnt>=STARVE_MAX).
//   rd_req_rdy = rd_req_vld & !wr_win; wr_req_rdy = wr_win. rdy is never asserted without vld.
//   Read grant: CEN=0, GWEN=1, A=rd_req_addr.
//   Write grant: CEN=0, GWEN=0, A=wr_req_addr, D=wr_req_data, WEN=~wr_req_mask.
//   No grant: idle outputs.
//  Starve cnt: +1 (saturating at STARVE_MAX) when wr_req_vld & !wr_req_rdy; cleared on write grant or when !wr_req_vld.
//  Read latency: rd_rsp_vld registered = read grant of previous cycle. Back-to-back reads give 1 rsp/cycle.
//  Same address, same cycle, both valid: read wins unless starved; read returns pre-write data.
//  Write then read of the same address on consecutive cycles returns the new data; no bypass logic required.
//  All-zero mask write still consumes the slot (CEN=0, GWEN=0, WEN='1); array unchanged.
//  Reset mid-INIT: sweep restarts at addr 0. Reset mid-read: pending rd_rsp_vld dropped (0 next cycle).
//  Address wrap: none in RUN; addresses are used as given, full range legal.
// STRUCTURE
//  Package ct_f_spsram_ctrl_pkg: state enum {ST_INIT, ST_RUN}; STARVE_CNT_W=4.
//  Sub-module ct_f_spsram_starve_cnt: saturating counter (inc, clr, sat flag).
//  Top: FSM + init pointer + grant mux + rsp valid flop.
// TESTING
//  1 Reset, INIT_EN=1, ADDR_WIDTH=11 -> init_done rises after exactly 2048 cycles. Then read 0x7FF -> 144'h0.
//  2 Write 0x123 data=144'hA5.., mask='1; next cycle read 0x123 -> rd_rsp_vld 1 cycle after grant, data=144'hA5..
//  3 rd_req_vld and wr_req_vld held high 8 cycles, STARVE_MAX=4 -> grants R,R,R,R,W,R,R,R.
//  4 Mask = 144'h0F over stored 0 with data='1 -> readback 144'h0F.
//    Then mask=0 write -> cycle consumed, readback unchanged.
//  5 RST at init ptr=0x400 -> sweep restarts at 0.
//    RST the cycle after a read grant -> rd_rsp_vld=0.
//  6 Requests during INIT -> rdy=0, sram_A follows init ptr. Same-addr R/W collision -> read returns old value.

Source files
------------

// File: rtl/ct_f_spsram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ct_f_spsram_ctrl_pkg
//  Brief    : Shared types and constants for the single-port SRAM arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package ct_f_spsram_ctrl_pkg;

    // Width of the write-starvation counter (holds STARVE_MAX up to 15)
    localparam int STARVE_CNT_W = 4;

    // Controller phase: zero-fill sweep, then normal arbitration
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ct_f_spsram_starve_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : ct_f_spsram_starve_cnt
//  Brief    : Saturating counter of consecutive stalled write cycles.
//  Revision : 1.0  initial release
// ============================================================================
module ct_f_spsram_starve_cnt
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int MAX_CNT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_inc,
    input  logic                    i_clr,
    output logic                    o_sat,
    output logic [STARVE_CNT_W-1:0] o_cnt
);

    localparam logic [STARVE_CNT_W-1:0] c_MAX = STARVE_CNT_W'(MAX_CNT);

    logic [STARVE_CNT_W-1:0] r_cnt;

    // Count stalled cycles, holding at the limit; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt < c_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sat = (r_cnt >= c_MAX);
    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ct_f_spsram_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ct_f_spsram_arb_ctrl
//  Brief    : Read/masked-write arbiter and zero-fill sequencer in front of a
//             single-port SRAM macro (one access per cycle).
//  Revision : 1.0  initial release
// ============================================================================
module ct_f_spsram_arb_ctrl
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 144,
    parameter int STARVE_MAX = 4,
    parameter int INIT_EN    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  init_done,
    input  logic                  rd_req_vld,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  rd_req_rdy,
    output logic                  rd_rsp_vld,
    output logic [DATA_WIDTH-1:0] rd_rsp_data,
    input  logic                  wr_req_vld,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [DATA_WIDTH-1:0] wr_req_data,
    input  logic [DATA_WIDTH-1:0] wr_req_mask,
    output logic                  wr_req_rdy,
    output logic [ADDR_WIDTH-1:0] sram_A,
    output logic                  sram_CEN,
    output logic                  sram_GWEN,
    output logic [DATA_WIDTH-1:0] sram_WEN,
    output logic [DATA_WIDTH-1:0] sram_D,
    input  logic [DATA_WIDTH-1:0] sram_Q
);

    localparam state_t c_RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic                    r_rsp_vld;

    logic                    w_run;
    logic                    w_init;
    logic                    w_sat;
    logic                    w_wr_win;
    logic                    w_rd_grant;
    logic [STARVE_CNT_W-1:0] w_cnt_unused;

    // Phase sequencer: sweep every address once, then stay in RUN until reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_RST_STATE;
            r_ptr   <= '0;
        end else if (r_state == ST_INIT) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == {ADDR_WIDTH{1'b1}}) begin
                r_state <= ST_RUN;
            end
        end
    end

    // Reset forces both phases inactive so nothing reaches the macro
    assign w_run  = (r_state == ST_RUN)  && !RST;
    assign w_init = (r_state == ST_INIT) && !RST;

    // Reads have priority unless the writer has waited STARVE_MAX cycles
    assign w_wr_win   = w_run && wr_req_vld && (!rd_req_vld || w_sat);
    assign w_rd_grant = w_run && rd_req_vld && !w_wr_win;

    assign rd_req_rdy = w_rd_grant;
    assign wr_req_rdy = w_wr_win;
    assign init_done  = (r_state == ST_RUN);

    ct_f_spsram_starve_cnt #(
        .MAX_CNT (STARVE_MAX)
    ) u_starve_cnt (
        .clk   (CLK),
        .rst   (RST),
        .i_inc (wr_req_vld && !w_wr_win),
        .i_clr (!wr_req_vld || w_wr_win),
        .o_sat (w_sat),
        .o_cnt (w_cnt_unused)
    );

    // Macro port mux: init write, granted write, granted read, or idle
    always_comb begin
        sram_CEN  = 1'b1;
        sram_GWEN = 1'b1;
        sram_WEN  = '1;
        sram_A    = '0;
        sram_D    = '0;
        if (w_init) begin
            sram_CEN  = 1'b0;
            sram_GWEN = 1'b0;
            sram_WEN  = '0;
            sram_A    = r_ptr;
        end else if (w_wr_win) begin
            sram_CEN  = 1'b0;
            sram_GWEN = 1'b0;
            sram_WEN  = ~wr_req_mask;
            sram_A    = wr_req_addr;
            sram_D    = wr_req_data;
        end else if (w_rd_grant) begin
            sram_CEN  = 1'b0;
            sram_A    = rd_req_addr;
        end
    end

    // Macro returns read data one cycle after the access; mark it valid then
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rsp_vld <= 1'b0;
        end else begin
            r_rsp_vld <= w_rd_grant;
        end
    end

    assign rd_rsp_vld  = r_rsp_vld;
    assign rd_rsp_data = r_rsp_vld ? sram_Q : '0;

endmodule
`default_nettype wire

// File: tb/tb_ct_f_spsram_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ct_f_spsram_arb_ctrl
//  Brief    : Directed, table-driven bench for ct_f_spsram_arb_ctrl with a
//             behavioural single-port SRAM model attached.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ct_f_spsram_arb_ctrl;

    localparam int AW = 11;
    localparam int DW = 144;
    localparam int NV = 21;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic          rd_req_vld;
    logic [AW-1:0] rd_req_addr;
    logic          rd_req_rdy;
    logic          rd_rsp_vld;
    logic [DW-1:0] rd_rsp_data;
    logic          wr_req_vld;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic [DW-1:0] wr_req_mask;
    logic          wr_req_rdy;
    logic [AW-1:0] sram_A;
    logic          sram_CEN;
    logic          sram_GWEN;
    logic [DW-1:0] sram_WEN;
    logic [DW-1:0] sram_D;
    logic [DW-1:0] sram_Q;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ct_f_spsram_arb_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STARVE_MAX (4),
        .INIT_EN    (1)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .init_done   (init_done),
        .rd_req_vld  (rd_req_vld),
        .rd_req_addr (rd_req_addr),
        .rd_req_rdy  (rd_req_rdy),
        .rd_rsp_vld  (rd_rsp_vld),
        .rd_rsp_data (rd_rsp_data),
        .wr_req_vld  (wr_req_vld),
        .wr_req_addr (wr_req_addr),
        .wr_req_data (wr_req_data),
        .wr_req_mask (wr_req_mask),
        .wr_req_rdy  (wr_req_rdy),
        .sram_A      (sram_A),
        .sram_CEN    (sram_CEN),
        .sram_GWEN   (sram_GWEN),
        .sram_WEN    (sram_WEN),
        .sram_D      (sram_D),
        .sram_Q      (sram_Q)
    );

    // Behavioural single-port macro: active-low enables, registered read port
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!sram_CEN) begin
            if (!sram_GWEN) begin
                mem[sram_A] <= (mem[sram_A] & sram_WEN) | (sram_D & ~sram_WEN);
            end else begin
                sram_Q <= mem[sram_A];
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rv;
        logic [AW-1:0] ra;
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] wm;
        logic          e_rr;
        logic          e_wr;
        logic          e_cen;
        logic          e_gwen;
        logic          e_rv;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic rv, input logic [AW-1:0] ra,
                                input logic wv, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                                input logic e_rr, input logic e_wr,
                                input logic e_cen, input logic e_gwen,
                                input logic e_rv, input logic [DW-1:0] e_rd);
        vec_t v;
        v.rv = rv; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd; v.wm = wm;
        v.e_rr = e_rr; v.e_wr = e_wr; v.e_cen = e_cen; v.e_gwen = e_gwen;
        v.e_rv = e_rv; v.e_rd = e_rd;
        return v;
    endfunction

    initial begin
        logic [DW-1:0] a5;
        logic [DW-1:0] p;
        logic [DW-1:0] ones;
        logic [DW-1:0] z;
        logic [DW-1:0] m0f;
        logic [DW-1:0] d5a;
        a5   = {18{8'hA5}};
        p    = {9{16'h1234}};
        ones = '1;
        z    = '0;
        m0f  = 144'h0F;
        d5a  = {18{8'h5A}};

        //                rv  ra      wv  wa      wd    wm    rr wr cen gwen rv rd
        vecs[0]  = mk(0, 11'h000, 1, 11'h123, a5,   ones, 0, 1, 0, 0, 0, z);
        vecs[1]  = mk(1, 11'h123, 0, 11'h000, z,    z,    1, 0, 0, 1, 0, z);
        vecs[2]  = mk(0, 11'h000, 0, 11'h000, z,    z,    0, 0, 1, 1, 1, a5);
        vecs[3]  = mk(0, 11'h000, 1, 11'h050, ones, m0f,  0, 1, 0, 0, 0, z);
        vecs[4]  = mk(1, 11'h050, 0, 11'h000, z,    z,    1, 0, 0, 1, 0, z);
        vecs[5]  = mk(0, 11'h000, 1, 11'h050, z,    z,    0, 1, 0, 0, 1, m0f);
        vecs[6]  = mk(1, 11'h050, 0, 11'h000, z,    z,    1, 0, 0, 1, 0, z);
        vecs[7]  = mk(0, 11'h000, 0, 11'h000, z,    z,    0, 0, 1, 1, 1, m0f);
        vecs[8]  = mk(1, 11'h123, 1, 11'h123, d5a,  ones, 1, 0, 0, 1, 0, z);
        vecs[9]  = mk(0, 11'h000, 0, 11'h000, z,    z,    0, 0, 1, 1, 1, a5);
        vecs[10] = mk(1, 11'h7FF, 1, 11'h7FE, p,    ones, 1, 0, 0, 1, 0, z);
        vecs[11] = mk(1, 11'h7FF, 1, 11'h7FE, p,    ones, 1, 0, 0, 1, 1, z);
        vecs[12] = mk(1, 11'h7FF, 1, 11'h7FE, p,    ones, 1, 0, 0, 1, 1, z);
        vecs[13] = mk(1, 11'h7FF, 1, 11'h7FE, p,    ones, 1, 0, 0, 1, 1, z);
        vecs[14] = mk(1, 11'h7FF, 1, 11'h7FE, p,    ones, 0, 1, 0, 0, 1, z);
        vecs[15] = mk(1, 11'h7FF, 1, 11'h7FE, p,    ones, 1, 0, 0, 1, 0, z);
        vecs[16] = mk(1, 11'h7FF, 1, 11'h7FE, p,    ones, 1, 0, 0, 1, 1, z);
        vecs[17] = mk(1, 11'h7FF, 1, 11'h7FE, p,    ones, 1, 0, 0, 1, 1, z);
        vecs[18] = mk(0, 11'h000, 0, 11'h000, z,    z,    0, 0, 1, 1, 1, z);
        vecs[19] = mk(1, 11'h7FE, 0, 11'h000, z,    z,    1, 0, 0, 1, 0, z);
        vecs[20] = mk(0, 11'h000, 0, 11'h000, z,    z,    0, 0, 1, 1, 1, p);

        // Reset with requests pending: no grants, idle macro
        rst = 1'b1;
        rd_req_vld = 1'b1; rd_req_addr = 11'h055;
        wr_req_vld = 1'b1; wr_req_addr = 11'h066;
        wr_req_data = '1;  wr_req_mask = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_rdy",    DW'(rd_req_rdy), DW'(0));
        chk("rst_wr_rdy",    DW'(wr_req_rdy), DW'(0));
        chk("rst_cen",       DW'(sram_CEN),   DW'(1));
        chk("rst_init_done", DW'(init_done),  DW'(0));
        chk("rst_rsp_vld",   DW'(rd_rsp_vld), DW'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Partial sweep up to 0x400, then reset it
        for (int k = 0; k < 1024; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("sweep_ptr_400", DW'(sram_A), DW'(11'h400));
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // Full sweep from address 0 with requests held high
        for (int k = 0; k < 2048; k++) begin
            @(negedge clk);
            if (k < 3 || k == 1024 || k == 2047) begin
                chk("init_addr",   DW'(sram_A),     DW'(k));
                chk("init_wr",     DW'({sram_CEN, sram_GWEN}), DW'(0));
                chk("init_wen",    sram_WEN,        '0);
                chk("init_rdy",    DW'({rd_req_rdy, wr_req_rdy}), DW'(0));
                chk("init_done_lo", DW'(init_done), DW'(0));
            end
            @(posedge clk); #1;
        end
        rd_req_vld = 1'b0; wr_req_vld = 1'b0;
        @(negedge clk);
        chk("init_done_hi", DW'(init_done), DW'(1));

        // Table of single-cycle vectors
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            rd_req_vld  = vecs[i].rv; rd_req_addr = vecs[i].ra;
            wr_req_vld  = vecs[i].wv; wr_req_addr = vecs[i].wa;
            wr_req_data = vecs[i].wd; wr_req_mask = vecs[i].wm;
            @(negedge clk);
            chk($sformatf("v%0d_rd_rdy", i), DW'(rd_req_rdy), DW'(vecs[i].e_rr));
            chk($sformatf("v%0d_wr_rdy", i), DW'(wr_req_rdy), DW'(vecs[i].e_wr));
            chk($sformatf("v%0d_cen_gwen", i), DW'({sram_CEN, sram_GWEN}),
                DW'({vecs[i].e_cen, vecs[i].e_gwen}));
            chk($sformatf("v%0d_rsp_vld", i), DW'(rd_rsp_vld), DW'(vecs[i].e_rv));
            chk($sformatf("v%0d_rsp_data", i), rd_rsp_data, vecs[i].e_rd);
            if (vecs[i].e_wr) begin
                chk($sformatf("v%0d_wen", i), sram_WEN, ~vecs[i].wm);
                chk($sformatf("v%0d_addr", i), DW'(sram_A), DW'(vecs[i].wa));
            end else if (vecs[i].e_rr) begin
                chk($sformatf("v%0d_addr", i), DW'(sram_A), DW'(vecs[i].ra));
            end
        end

        // Reset the cycle after a read grant drops the response
        @(posedge clk); #1;
        rd_req_vld = 1'b1; rd_req_addr = 11'h7FE;
        @(negedge clk);
        chk("rr_grant", DW'(rd_req_rdy), DW'(1));
        @(posedge clk); #1;
        rst = 1'b1; rd_req_vld = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rr_rsp_dropped", DW'(rd_rsp_vld), DW'(0));
        chk("rr_init_again",  DW'(init_done),  DW'(0));
        chk("rr_sweep_addr0", DW'(sram_A),     DW'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
